// File: rtl/pong_match_ctrl.sv
// Match sequencer for the two-player paddle game: game state, scores, serve timing and
// ball gating. Every output is a register.
module pong_match_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 120,
    parameter int SCORE_W     = 4,
    parameter int DELAY_W     = 8
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    input  logic               frame_tick_i,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic               miss_left_i,
    input  logic               miss_right_i,
    output logic               ball_enable_o,
    output logic               serve_o,
    output logic               serve_dir_o,
    output logic [SCORE_W-1:0] score_1_o,
    output logic [SCORE_W-1:0] score_2_o,
    output logic               game_over_o,
    output logic               winner_o,
    output logic               paused_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        PLAY       = 3'd2,
        GAME_OVER  = 3'd3
    } state_e;

    localparam logic [DELAY_W-1:0] DELAY_LOAD = DELAY_W'(SERVE_DELAY);
    localparam logic [SCORE_W-1:0] WIN_M1     = SCORE_W'(WIN_SCORE - 1);

    state_e               state_q, state_d;
    logic [SCORE_W-1:0]   score1_q, score1_d, score2_q, score2_d;
    logic [DELAY_W-1:0]   cnt_q, cnt_d;
    logic                 serve_q, serve_d, dir_q, dir_d, ben_q, ben_d;
    logic                 gover_q, gover_d, winner_q, winner_d, paused_q, paused_d;
    logic                 start_prev_q, pause_prev_q;

    logic start_edge, pause_edge, miss_ok, ml_only, mr_only, both_miss, p1_wins, p2_wins;

    assign start_edge = start_i & ~start_prev_q;
    assign pause_edge = pause_i & ~pause_prev_q;
    assign miss_ok    = (state_q == PLAY) & ~paused_q;
    assign ml_only    = miss_ok & miss_left_i & ~miss_right_i;
    assign mr_only    = miss_ok & miss_right_i & ~miss_left_i;
    assign both_miss  = miss_ok & miss_left_i & miss_right_i;
    assign p1_wins    = mr_only & (score1_q == WIN_M1);
    assign p2_wins    = ml_only & (score2_q == WIN_M1);

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            score1_q     <= '0;
            score2_q     <= '0;
            cnt_q        <= '0;
            serve_q      <= 1'b0;
            dir_q        <= 1'b1;
            ben_q        <= 1'b0;
            gover_q      <= 1'b0;
            winner_q     <= 1'b0;
            paused_q     <= 1'b0;
            start_prev_q <= 1'b1;
            pause_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            cnt_q        <= cnt_d;
            serve_q      <= serve_d;
            dir_q        <= dir_d;
            ben_q        <= ben_d;
            gover_q      <= gover_d;
            winner_q     <= winner_d;
            paused_q     <= paused_d;
            start_prev_q <= start_i;
            pause_prev_q <= pause_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start_edge) state_d = SERVE_WAIT;
            SERVE_WAIT: if (!paused_q && cnt_q == '0) state_d = PLAY;
            PLAY: begin
                if (p1_wins || p2_wins)                     state_d = GAME_OVER;
                else if (ml_only || mr_only || both_miss)   state_d = SERVE_WAIT;
            end
            GAME_OVER:  if (start_edge) state_d = SERVE_WAIT;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        score1_d = score1_q;
        score2_d = score2_q;
        cnt_d    = cnt_q;
        serve_d  = 1'b0;
        dir_d    = dir_q;
        winner_d = winner_q;
        paused_d = paused_q;
        case (state_q)
            IDLE, GAME_OVER: begin
                if (start_edge) begin
                    score1_d = '0;
                    score2_d = '0;
                    dir_d    = 1'b1;
                    winner_d = 1'b0;
                    cnt_d    = DELAY_LOAD;
                end
            end
            SERVE_WAIT: begin
                if (!paused_q) begin
                    if (cnt_q == '0)       serve_d = 1'b1;
                    else if (frame_tick_i) cnt_d   = cnt_q - 1'b1;
                end
            end
            PLAY: begin
                if (ml_only || mr_only || both_miss) cnt_d = DELAY_LOAD;
                // the next serve goes toward the player who just lost the point
                if (ml_only) begin
                    score2_d = score2_q + 1'b1;
                    dir_d    = 1'b0;
                    if (p2_wins) winner_d = 1'b1;
                end
                if (mr_only) begin
                    score1_d = score1_q + 1'b1;
                    dir_d    = 1'b1;
                    if (p1_wins) winner_d = 1'b0;
                end
            end
            default: ;
        endcase
        if ((state_q == SERVE_WAIT || state_q == PLAY) && pause_edge) paused_d = ~paused_q;
        if (state_d == IDLE || state_d == GAME_OVER) paused_d = 1'b0;
    end

    assign ben_d   = (state_d == PLAY) & ~paused_d;
    assign gover_d = (state_d == GAME_OVER);

    assign ball_enable_o = ben_q;
    assign serve_o       = serve_q;
    assign serve_dir_o   = dir_q;
    assign score_1_o     = score1_q;
    assign score_2_o     = score2_q;
    assign game_over_o   = gover_q;
    assign winner_o      = winner_q;
    assign paused_o      = paused_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with WIN_SCORE=2 and SERVE_DELAY=3.
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, tick, start, pause, ml, mr;
    logic       ben, serve, dir, gover, winner, paused;
    logic [3:0] s1, s2;
    logic [2:0] st;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pong_match_ctrl #(.WIN_SCORE(2), .SERVE_DELAY(3), .SCORE_W(4), .DELAY_W(8)) dut (
        .clock_i(clk), .reset_ni(rst_n), .frame_tick_i(tick), .start_i(start),
        .pause_i(pause), .miss_left_i(ml), .miss_right_i(mr),
        .ball_enable_o(ben), .serve_o(serve), .serve_dir_o(dir),
        .score_1_o(s1), .score_2_o(s2), .game_over_o(gover), .winner_o(winner),
        .paused_o(paused), .state_o(st)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ftick();
        tick = 1'b1; step();
        tick = 1'b0; step();
    endtask

    task automatic pulse_start();
        start = 1'b1; step();
        start = 1'b0; step();
    endtask

    task automatic pulse_pause();
        pause = 1'b1; step();
        pause = 1'b0; step();
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; start = 1'b1; pause = 1'b1; ml = 1'b0; mr = 1'b0;
        step(3);
        chk("rst_state", st, 0);
        chk("rst_serve", serve, 0);
        chk("rst_dir", dir, 1);
        chk("rst_ben", ben, 0);
        chk("rst_s1", s1, 0);
        chk("rst_s2", s2, 0);
        chk("rst_gover", gover, 0);
        chk("rst_winner", winner, 0);
        chk("rst_paused", paused, 0);

        // buttons held through reset release must not act
        rst_n = 1'b1;
        step(3);
        chk("held_state", st, 0);
        chk("held_serve", serve, 0);
        chk("held_paused", paused, 0);
        start = 1'b0; pause = 1'b0;
        step();

        // start -> countdown 3 -> serve after the 3rd tick
        start = 1'b1; step();
        chk("start_state", st, 1);
        chk("start_cnt", dut.cnt_q, 3);
        chk("start_ben", ben, 0);
        start = 1'b0; step();
        ftick();
        ftick();
        chk("cnt_after2", dut.cnt_q, 1);
        tick = 1'b1; step();
        chk("cnt_zero", dut.cnt_q, 0);
        chk("no_serve_yet", serve, 0);
        chk("still_wait", st, 1);
        tick = 1'b0; step();
        chk("serve_pulse", serve, 1);
        chk("serve_state", st, 2);
        chk("serve_dir1", dir, 1);
        chk("serve_ben", ben, 1);
        step();
        chk("serve_1cyc", serve, 0);
        chk("play_state", st, 2);

        // miss_left -> point to player 2
        ml = 1'b1; step(); ml = 1'b0;
        chk("ml_s2", s2, 1);
        chk("ml_s1", s1, 0);
        chk("ml_dir", dir, 0);
        chk("ml_state", st, 1);
        chk("ml_ben", ben, 0);
        chk("ml_cnt", dut.cnt_q, 3);
        ftick(); ftick(); ftick();
        chk("reserve_pulse", serve, 1);
        chk("reserve_dir", dir, 0);
        step();

        // simultaneous misses replay the point
        ml = 1'b1; mr = 1'b1; step(); ml = 1'b0; mr = 1'b0;
        chk("both_s1", s1, 0);
        chk("both_s2", s2, 1);
        chk("both_dir", dir, 0);
        chk("both_state", st, 1);
        ftick(); ftick();
        chk("both_wait", st, 1);
        chk("both_noserve", serve, 0);
        ftick();
        chk("both_reserve", serve, 1);
        chk("both_play", st, 2);
        step();

        // player 1 wins at WIN_SCORE=2
        mr = 1'b1; step(); mr = 1'b0;
        chk("mr1_s1", s1, 1);
        chk("mr1_dir", dir, 1);
        chk("mr1_state", st, 1);
        ftick(); ftick(); ftick(); step();
        chk("mr2_pre", st, 2);
        mr = 1'b1; step(); mr = 1'b0;
        chk("win_s1", s1, 2);
        chk("win_state", st, 3);
        chk("win_gover", gover, 1);
        chk("win_winner", winner, 0);
        chk("win_ben", ben, 0);
        ml = 1'b1; mr = 1'b0; step(); ml = 1'b0; mr = 1'b1; step(); mr = 1'b0;
        chk("go_s1", s1, 2);
        chk("go_s2", s2, 1);
        chk("go_state", st, 3);
        pulse_pause();
        chk("go_nopause", paused, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("rs_s1", s1, 0);
        chk("rs_s2", s2, 0);
        chk("rs_state", st, 1);
        chk("rs_gover", gover, 0);
        chk("rs_dir", dir, 1);
        chk("rs_cnt", dut.cnt_q, 3);
        step();

        // pause freezes the countdown at 2
        ftick();
        chk("p_cnt2", dut.cnt_q, 2);
        pulse_pause();
        chk("p_on", paused, 1);
        repeat (10) ftick();
        chk("p_hold", dut.cnt_q, 2);
        chk("p_state", st, 1);
        chk("p_noserve", serve, 0);
        pulse_pause();
        chk("p_off", paused, 0);
        ftick();
        chk("p_resume", dut.cnt_q, 1);
        ftick();
        chk("p_serve", serve, 1);
        chk("p_play", st, 2);
        step();

        // pause in PLAY gates the ball and ignores misses
        pulse_pause();
        chk("pp_on", paused, 1);
        chk("pp_ben", ben, 0);
        ml = 1'b1; step(); ml = 1'b0;
        chk("pp_s2", s2, 0);
        chk("pp_state", st, 2);
        pulse_pause();
        chk("pp_ben1", ben, 1);

        // start ignored during play; reset mid-operation
        pulse_start();
        chk("play_start_ign", st, 2);
        rst_n = 1'b0; step();
        chk("mid_rst_state", st, 0);
        chk("mid_rst_ben", ben, 0);
        chk("mid_rst_dir", dir, 1);
        rst_n = 1'b1; step();
        chk("mid_rst_serve", serve, 0);
        chk("mid_rst_idle", st, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
